// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and counter sizing for the seven-segment scanner.
package seg7_pkg;

   // Active-low glyphs, order {dp,g,f,e,d,c,b,a}, dp off
   localparam logic [7:0] SEG_0    = 8'hC0;
   localparam logic [7:0] SEG_1    = 8'hF9;
   localparam logic [7:0] SEG_2    = 8'hA4;
   localparam logic [7:0] SEG_3    = 8'hB0;
   localparam logic [7:0] SEG_4    = 8'h99;
   localparam logic [7:0] SEG_5    = 8'h92;
   localparam logic [7:0] SEG_6    = 8'h82;
   localparam logic [7:0] SEG_7    = 8'hF8;
   localparam logic [7:0] SEG_8    = 8'h80;
   localparam logic [7:0] SEG_9    = 8'h98;
   localparam logic [7:0] SEG_DASH = 8'hBF;
   localparam logic [7:0] SEG_OFF  = 8'hFF;

   typedef enum logic {
      GUARD = 1'b0,
      DRIVE = 1'b1
   } state_e;

   // Bits needed for a counter that runs 0..n-1 (at least one bit)
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment glyph with decimal point and blanking.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] glyph_c
);

   // Glyph lookup; non-BCD codes show a dash, blank overrides everything
   always_comb begin
      glyph_c = SEG_DASH;
      case (bcd)
         4'd0:    glyph_c = SEG_0;
         4'd1:    glyph_c = SEG_1;
         4'd2:    glyph_c = SEG_2;
         4'd3:    glyph_c = SEG_3;
         4'd4:    glyph_c = SEG_4;
         4'd5:    glyph_c = SEG_5;
         4'd6:    glyph_c = SEG_6;
         4'd7:    glyph_c = SEG_7;
         4'd8:    glyph_c = SEG_8;
         4'd9:    glyph_c = SEG_9;
         default: glyph_c = SEG_DASH;
      endcase
      glyph_c[7] = ~dp;
      if (blank) glyph_c = SEG_OFF;
   end

endmodule

// File: rtl/seg7_scan_blink.sv
// Multiplexed seven-segment scanner with guard blanking and blinking edit cursor.
// Optional brightness control (dim input, PWM inside the drive window) with SEG7_DIM_EN.
module seg7_scan_blink
   import seg7_pkg::*;
#(
   parameter  int unsigned NUM_DIGITS = 8,
   parameter  int unsigned CLK_HZ     = 100_000_000,
   parameter  int unsigned SCAN_HZ    = 1000,
   parameter  int unsigned BLINK_HZ   = 2,
   parameter  int unsigned GUARD_CYC  = 16,
   localparam int unsigned IDX_W      = $clog2(NUM_DIGITS)
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic                    edit_en,
   input  logic [IDX_W-1:0]        cursor,
`ifdef SEG7_DIM_EN
   input  logic [3:0]              dim,
`endif
   output logic [NUM_DIGITS-1:0]   seg_en,
   output logic [7:0]              seg_out,
   output logic [IDX_W-1:0]        scan_idx,
   output logic                    blink_phase
);

   localparam int unsigned SLOT_CYC   = CLK_HZ / SCAN_HZ;
   localparam int unsigned BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
   localparam int unsigned SLOT_W     = cnt_w(SLOT_CYC);
   localparam int unsigned BLINK_W    = cnt_w(BLINK_HALF);

   state_e              state;
   logic [SLOT_W-1:0]   slot_cnt;
   logic [BLINK_W-1:0]  blink_cnt;
   logic                edit_d;

   logic [3:0]            bcd_sel_c;
   logic                  dp_sel_c;
   logic                  blank_sel_c;
   logic                  cursor_hit_c;
   logic                  dark_c;
   logic [7:0]            glyph_c;
   logic [NUM_DIGITS-1:0] en_drive_c;

   // Select the current digit's inputs and build its active-low enable
   always_comb begin
      bcd_sel_c   = 4'd0;
      dp_sel_c    = 1'b0;
      blank_sel_c = 1'b0;
      en_drive_c  = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (IDX_W'(i) == scan_idx) begin
            bcd_sel_c     = digits[4*i +: 4];
            dp_sel_c      = dp_mask[i];
            blank_sel_c   = blank_mask[i];
            en_drive_c[i] = 1'b0;
         end
      end
      // scan_idx never reaches an out-of-range cursor, so no digit blinks then
      cursor_hit_c = edit_en && blink_phase && (cursor == scan_idx);
      dark_c       = blank_sel_c || cursor_hit_c;
   end

   seg7_decode u_decode (
      .bcd     (bcd_sel_c),
      .dp      (dp_sel_c),
      .blank   (dark_c),
      .glyph_c (glyph_c)
   );

   // Free-running blink divider; an edit_en rising edge restarts it in the lit half
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         edit_d      <= 1'b0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         edit_d <= edit_en;
         if (edit_en && !edit_d) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
         end else if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
         end
      end
   end

`ifdef SEG7_DIM_EN
   localparam int unsigned DRIVE_CYC = SLOT_CYC - GUARD_CYC;
   localparam int unsigned SUB_CYC   = DRIVE_CYC / 16;

   logic [3:0] dim_q;
   logic       dim_lit_c;

   // Tube stays lit for the first dim+1 sub-windows of the next drive cycle
   always_comb begin
      dim_lit_c = (dim_q == 4'hF) ||
                  ((32'(slot_cnt) + 32'd1 - GUARD_CYC) < ((32'(dim_q) + 32'd1) * SUB_CYC));
   end
`endif

   // Slot sequencer: guard blanking, snapshot, then drive the selected tube
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= GUARD;
         slot_cnt <= '0;
         scan_idx <= '0;
         seg_en   <= '1;
         seg_out  <= SEG_OFF;
`ifdef SEG7_DIM_EN
         dim_q    <= 4'hF;
`endif
      end else begin
         case (state)
            GUARD: begin
               slot_cnt <= slot_cnt + SLOT_W'(1);
               if (slot_cnt == SLOT_W'(GUARD_CYC - 1)) begin
                  state   <= DRIVE;
                  seg_en  <= en_drive_c;
                  seg_out <= glyph_c;
`ifdef SEG7_DIM_EN
                  dim_q   <= dim;
`endif
               end
            end
            DRIVE: begin
               if (slot_cnt == SLOT_W'(SLOT_CYC - 1)) begin
                  state    <= GUARD;
                  slot_cnt <= '0;
                  seg_en   <= '1;
                  seg_out  <= SEG_OFF;
                  scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
               end else begin
                  slot_cnt <= slot_cnt + SLOT_W'(1);
`ifdef SEG7_DIM_EN
                  seg_en   <= dim_lit_c ? en_drive_c : '1;
`endif
               end
            end
            default: begin
               state    <= GUARD;
               slot_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_scan_blink.sv
// Directed bench for seg7_scan_blink: scan order, decode, blink cursor, snapshot and reset.
module tb_seg7_scan_blink;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] digits;
   logic [7:0]  dp_mask;
   logic [7:0]  blank_mask;
   logic        edit_en;
   logic [2:0]  cursor;
   logic [7:0]  seg_en;
   logic [7:0]  seg_out;
   logic [2:0]  scan_idx;
   logic        blink_phase;
`ifdef SEG7_DIM_EN
   logic [3:0]  dim = 4'hF;
`endif

   typedef struct {
      logic [2:0] idx;
      logic [7:0] en;
      logic [7:0] seg;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   seg7_scan_blink #(
      .NUM_DIGITS (8),
      .CLK_HZ     (1000),
      .SCAN_HZ    (100),
      .BLINK_HZ   (5),
      .GUARD_CYC  (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .digits      (digits),
      .dp_mask     (dp_mask),
      .blank_mask  (blank_mask),
      .edit_en     (edit_en),
      .cursor      (cursor),
`ifdef SEG7_DIM_EN
      .dim         (dim),
`endif
      .seg_en      (seg_en),
      .seg_out     (seg_out),
      .scan_idx    (scan_idx),
      .blink_phase (blink_phase)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [7:0] glyph(input logic [3:0] d, input logic dp);
      logic [7:0] g;
      case (d)
         4'd0: g = 8'hC0;
         4'd1: g = 8'hF9;
         4'd2: g = 8'hA4;
         4'd3: g = 8'hB0;
         4'd4: g = 8'h99;
         4'd5: g = 8'h92;
         4'd6: g = 8'h82;
         4'd7: g = 8'hF8;
         4'd8: g = 8'h80;
         4'd9: g = 8'h98;
         default: g = 8'hBF;
      endcase
      if (dp) g = g & 8'h7F;
      return g;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int idx, input logic [7:0] seg);
      exp_t e;
      logic [7:0] one;
      one   = 8'h01;
      e.idx = 3'(idx);
      e.en  = ~(one << idx);
      e.seg = seg;
      sb.push_back(e);
   endtask

   // Entered on the first guard cycle of a slot; leaves on the first guard cycle of the next
   task automatic next_slot(input bit do_chg, input logic [31:0] new_digits);
      int         g;
      int         d;
      exp_t       e;
      logic [7:0] en0;
      logic [7:0] s0;
      bit         stable;
      g = 0;
      while (seg_en === 8'hFF && g < 40) begin
         g++;
         @(negedge clk);
      end
      chk("guard_len", 32'(g), 32'd2);
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("slot_idx", 32'(scan_idx), 32'(e.idx));
         chk("slot_en", 32'(seg_en), 32'(e.en));
         chk("slot_seg", 32'(seg_out), 32'(e.seg));
      end
      en0    = seg_en;
      s0     = seg_out;
      d      = 0;
      stable = 1'b1;
      while (seg_en === en0 && d < 40) begin
         if (seg_out !== s0) stable = 1'b0;
         d++;
         if (do_chg && d == 4) digits = new_digits;
         @(negedge clk);
      end
      chk("drive_len", 32'(d), 32'd8);
      chk("drive_stable", 32'(stable), 32'd1);
   endtask

   initial begin
      int g;
      rst        = 1'b0;
      digits     = 32'h7654_3210;
      dp_mask    = 8'h00;
      blank_mask = 8'h00;
      edit_en    = 1'b0;
      cursor     = 3'd0;
      repeat (3) @(negedge clk);
      chk("rst_seg_en", 32'(seg_en), 32'hFF);
      chk("rst_seg_out", 32'(seg_out), 32'hFF);
      chk("rst_scan_idx", 32'(scan_idx), 32'd0);
      chk("rst_blink", 32'(blink_phase), 32'd0);

      // Reset scan through all digits and wrap back to 0
      rst = 1'b1;
      for (int i = 0; i < 8; i++) push(i, glyph(4'(i), 1'b0));
      push(0, 8'hC0);
      repeat (9) next_slot(1'b0, 32'h0);

      // Dash with decimal point on digit 2, forced blank on digit 3
      digits     = 32'h7654_3B10;
      dp_mask    = 8'h04;
      blank_mask = 8'h08;
      push(1, 8'hF9);
      push(2, 8'h3F);
      push(3, 8'hFF);
      push(4, 8'h99);
      repeat (4) next_slot(1'b0, 32'h0);
      digits     = 32'h7654_3210;
      dp_mask    = 8'h00;
      blank_mask = 8'h00;

      // Cursor on digit 5; snapshot of visit v happens 80*v cycles after the edit_en edge
      cursor  = 3'd5;
      edit_en = 1'b1;
      for (int v = 0; v < 5; v++) begin
         for (int k = 0; k < 8; k++) begin
            int s;
            s = (5 + k) % 8;
            if (s == 5 && (((80 * v) / 100) % 2) == 1) push(s, 8'hFF);
            else push(s, glyph(4'(s), 1'b0));
         end
      end
      repeat (40) next_slot(1'b0, 32'h0);
      chk("blink_phase_400", 32'(blink_phase), 32'd1);
      edit_en = 1'b0;
      push(5, 8'h92);
      push(6, 8'h82);
      push(7, 8'hF8);
      repeat (3) next_slot(1'b0, 32'h0);

      // Digit 0 changes mid-drive; current slot holds, next visit shows it
      push(0, 8'hC0);
      next_slot(1'b1, 32'h7654_3218);
      for (int i = 1; i < 8; i++) push(i, glyph(4'(i), 1'b0));
      push(0, 8'h80);
      repeat (8) next_slot(1'b0, 32'h0);

      // Reset asserted in the middle of digit 4's drive
      push(1, 8'hF9);
      push(2, 8'hA4);
      push(3, 8'hB0);
      repeat (3) next_slot(1'b0, 32'h0);
      g = 0;
      while (seg_en === 8'hFF && g < 40) begin
         g++;
         @(negedge clk);
      end
      chk("pre_rst_en", 32'(seg_en), 32'hEF);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_seg_en", 32'(seg_en), 32'hFF);
      chk("midrst_seg_out", 32'(seg_out), 32'hFF);
      chk("midrst_idx", 32'(scan_idx), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      push(0, 8'h80);
      push(1, 8'hF9);
      repeat (2) next_slot(1'b0, 32'h0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_blink.md
Name: seg7_scan_blink

Overview:
Parametrised multiplexed seven-segment scanner for the clock's display bank. It time-multiplexes NUM_DIGITS BCD digits onto the shared segment bus, with per-digit decimal point and blanking, and a blinking edit cursor. Everything runs on the single system clock using internal prescaler ticks; there are no derived clocks. A guard interval blanks all digits between slots to suppress ghosting.

Parameters:
NUM_DIGITS, 8, number of tube positions; must be ≥2.
CLK_HZ, 100_000_000, system clock frequency.
SCAN_HZ, 1000, per-digit slot rate; SLOT_CYC = CLK_HZ/SCAN_HZ.
BLINK_HZ, 2, cursor blink rate (full period); BLINK_HALF = CLK_HZ/(2*BLINK_HZ).
GUARD_CYC, 16, all-off cycles at the start of every slot; must satisfy 1 ≤ GUARD_CYC < SLOT_CYC.
IDX_W (localparam), $clog2(NUM_DIGITS), width of the digit index.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-low reset; 0 = reset.
digits  in  4*NUM_DIGITS  BCD value of digit i on bits [4i+3:4i]; digit 0 is the rightmost tube.
dp_mask  in  NUM_DIGITS  1 = light the decimal point of digit i.
blank_mask  in  NUM_DIGITS  1 = force digit i dark.
edit_en  in  1  edit mode; enables cursor blink.
cursor  in  IDX_W  index of the digit being edited.
seg_en  out  NUM_DIGITS  tube enables, active-low, at most one low.
seg_out  out  8  segments, active-low, order {dp,g,f,e,d,c,b,a}.
scan_idx  out  IDX_W  index of the digit currently driven.
blink_phase  out  1  0 = lit half of the blink period, 1 = dark half.

Behaviour:
- Reset (rst=0, async): state=GUARD, scan_idx=0, slot and blink counters=0, blink_phase=0, seg_en=all 1, seg_out=8'hFF.
- FSM with two states:
  - GUARD: seg_en=all 1, seg_out=8'hFF for GUARD_CYC cycles. On the last cycle, snapshot digits/dp/blank/cursor-match for scan_idx into a register, then go to DRIVE.
  - DRIVE: seg_en[scan_idx]=0 and seg_out=the snapshot glyph for SLOT_CYC-GUARD_CYC cycles. Then scan_idx increments, wrapping from NUM_DIGITS-1 to 0, and the FSM returns to GUARD.
  - Each slot is exactly SLOT_CYC cycles.
- Input changes during DRIVE do not affect the current slot. Outputs are registered: new inputs appear at the next DRIVE entry, one cycle after the snapshot.
- Decode:
  - 0–9 use standard glyphs (0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=98, with dp off).
  - Values 10–15 show a dash, 8'hBF.
  - seg_out[7] = ~dp_mask[i].
- Dark digit: when blank_mask[i]=1, or when edit_en=1 with cursor==i and blink_phase=1, seg_out=8'hFF. seg_en is still asserted, so slot timing is unchanged.
- Blink counter:
  - Free-running. blink_phase toggles every BLINK_HALF cycles.
  - On an edit_en rising edge (registered edge detect), the counter clears and blink_phase=0, so the cursor starts in its lit half.
- cursor ≥ NUM_DIGITS: no digit blinks.
- When edit_en=0, blinking stops from the next snapshot onward.
- Reset asserted mid-slot: outputs go to their reset values immediately. After release, scanning restarts at digit 0 in GUARD.

Optional Feature:
SEG7_DIM_EN.
- Defined: adds input dim [3:0]. The DRIVE slot is split into 16 equal sub-windows. seg_en[scan_idx] is low only during the first dim+1 sub-windows and high for the rest, while seg_out holds its value. dim=15 gives full brightness. dim is sampled with the snapshot.
- Undefined: no dim port, always full brightness.

Decomposition:
- Package seg7_pkg holds:
  - Glyph constants SEG_0..SEG_9, SEG_DASH, SEG_OFF.
  - The FSM state enum (GUARD, DRIVE).
  - A function computing counter widths.
- One sub-module, seg7_decode: a combinational BCD→glyph map with dp and blank inputs. The scanner instantiates it once, on the snapshot path.

Test Plan:
(All scenarios use CLK_HZ=1000, SCAN_HZ=100, so SLOT_CYC=10; GUARD_CYC=2; BLINK_HZ=5, so BLINK_HALF=100; NUM_DIGITS=8.)
- Reset scan: release rst, digits=0x76543210 → seg_en=FF for 2 cycles, then FE with seg_out=C0 for 8 cycles. After that FF for 2, then FD with seg_out=F9, continuing through 7F with F8. scan_idx wraps 7→0 after 80 cycles.
- Decode/dp: digit 2=4'hB, dp_mask=8'h04 → slot 2 shows seg_out=8'h3F (dash plus dp). blank_mask=8'h08 → slot 3 shows seg_out=FF with seg_en=F7.
- Blink: edit_en rises with cursor=5 → slot 5 is lit (seg_out=92 for digit 5) for 100 cycles, dark (FF) for the next 100, and so on. Digits other than 5 are never dark.
- Snapshot: change digit 0 from 0 to 8 in the middle of its DRIVE slot → seg_out stays C0 until the slot ends. The next visit to slot 0 shows 80.
- Mid-slot reset: assert rst during the DRIVE of digit 4 → seg_en=FF and seg_out=FF in the same cycle, asynchronously. After release, scanning restarts at scan_idx=0 in GUARD.
- SEG7_DIM_EN with dim=7: the DRIVE slot is resized to 160 cycles (SLOT_CYC=162, GUARD_CYC=2), giving 10-cycle sub-windows → seg_en is low for 80 cycles and high for 80 cycles. dim=15 → low for all 160 cycles.
